// File: rtl/hilo_md_ctrl.sv
// HI/LO register pair with a multi-cycle multiply/divide unit for the E stage.
// Results are computed at start, held pending, and committed when the busy count expires.
module hilo_md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        hilo_sel,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hilo_E,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;
  logic             start_req;

  function automatic logic [63:0] mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    return pa * pb;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Signed divide done on magnitudes so that 0x80000000 / -1 wraps deterministically.
  function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic [31:0] ua, ub, q, r;
    ua = a[31] ? unsigned'(-a) : unsigned'(a);
    ub = b[31] ? unsigned'(-b) : unsigned'(b);
    if (ub == 32'd0) return 64'd0;
    q = ua / ub;
    r = ua % ub;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  assign start_req = md_en && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign busy      = (state == RUN);
  assign stall_md  = md_use_D & (busy | start_req);
  assign hilo_E    = hilo_sel ? hi : lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_en) begin
            case (md_op)
              OP_MULT: begin
                {pend_hi, pend_lo} <= mul_s(rs_E, rt_E);
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
                state   <= RUN;
              end
              OP_MULTU: begin
                {pend_hi, pend_lo} <= mul_u(rs_E, rt_E);
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
                state   <= RUN;
              end
              // Divide by zero still occupies the unit but never commits.
              OP_DIV: begin
                {pend_hi, pend_lo} <= div_s(rs_E, rt_E);
                pend_wr <= (rt_E != 32'd0);
                cnt     <= CNT_W'(DIV_CYCLES);
                state   <= RUN;
              end
              OP_DIVU: begin
                {pend_hi, pend_lo} <= div_u(rs_E, rt_E);
                pend_wr <= (rt_E != 32'd0);
                cnt     <= CNT_W'(DIV_CYCLES);
                state   <= RUN;
              end
              OP_MTHI: hi <= rs_E;
              OP_MTLO: lo <= rs_E;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed vector table, corner sequences,
// and random ops compared with an arithmetic reference model.
module tb_hilo_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_en;
  logic [2:0]  md_op;
  logic [31:0] rs_E, rt_E;
  logic        hilo_sel;
  logic        md_use_D;
  logic        busy, stall_md;
  logic [31:0] hilo_E, hi, lo;

  int checks = 0;
  int failures = 0;

  hilo_md_ctrl dut (
    .clk(clk), .reset(reset), .md_en(md_en), .md_op(md_op),
    .rs_E(rs_E), .rt_E(rt_E), .hilo_sel(hilo_sel), .md_use_D(md_use_D),
    .busy(busy), .stall_md(stall_md), .hilo_E(hilo_E), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: HI/LO after an op, and its busy length, from the arithmetic rules.
  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] mh, inout logic [31:0] ml, output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] p;
    cyc = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; cyc = 5; end
      3'd2: begin p = 64'(a) * 64'(b); mh = p[63:32]; ml = p[31:0]; cyc = 5; end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          ml = q[31:0]; mh = r[31:0];
        end
      end
      3'd4: begin
        cyc = 10;
        if (b != 0) begin ml = a / b; mh = a % b; end
      end
      3'd5: mh = a;
      3'd6: ml = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_en = 1'b1; md_op = op; rs_E = a; rt_E = b;
    tick();
    md_en = 1'b0; md_op = 3'd0;
  endtask

  // Counts busy cycles (bounded), optionally injects an op mid-flight, and checks hi/lo hold.
  task automatic wait_idle(output int n, input bit inject, output bit hold_ok);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; hold_ok = 1'b1; n = 0;
    while (busy && n < 200) begin
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      if (inject && n == 1) begin
        md_en = 1'b1; md_op = 3'($urandom_range(1, 6)); rs_E = $urandom; rt_E = $urandom;
      end else begin
        md_en = 1'b0; md_op = 3'd0;
      end
      n++;
      tick();
    end
    md_en = 1'b0; md_op = 3'd0;
  endtask

  initial begin
    int          n;
    bit          hold_ok;
    logic [31:0] mh, ml;
    int          ecyc;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{3'd2, 32'hFFFFFFFF, 32'd2,          5,  32'h00000001, 32'hFFFFFFFE};
    vecs[1] = '{3'd1, 32'hFFFFFFFD, 32'd7,          5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,          10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd4, 32'd7,        32'd2,          10, 32'h00000001, 32'h00000003};
    vecs[4] = '{3'd5, 32'h00001234, 32'd0,          0,  32'h00001234, 32'h00000003};
    vecs[5] = '{3'd6, 32'h00005678, 32'd0,          0,  32'h00001234, 32'h00005678};
    vecs[6] = '{3'd3, 32'h00000099, 32'd0,          10, 32'h00001234, 32'h00005678};
    vecs[7] = '{3'd0, 32'hAAAAAAAA, 32'd1,          0,  32'h00001234, 32'h00005678};
    vecs[8] = '{3'd7, 32'hAAAAAAAA, 32'd1,          0,  32'h00001234, 32'h00005678};
    vecs[9] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,   10, 32'h00000000, 32'h80000000};

    reset = 1'b1; md_en = 1'b0; md_op = 3'd0; rs_E = '0; rt_E = '0;
    hilo_sel = 1'b0; md_use_D = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", 32'(stall_md), 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n, 1'b0, hold_ok);
      chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_hold", i), 32'(hold_ok), 32'd1);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
    end

    // Stall sequencing around a multu, with an illegal mthi slipped in while busy.
    md_use_D = 1'b1;
    md_en = 1'b1; md_op = 3'd2; rs_E = 32'h00010000; rt_E = 32'h00030000;
    #1;
    chk("stall_start", 32'(stall_md), 32'd1);
    tick();
    md_en = 1'b0; md_op = 3'd0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_busy%0d", c), 32'(stall_md), 32'd1);
      if (c == 1) begin
        md_en = 1'b1; md_op = 3'd5; rs_E = 32'hDEADBEEF;
      end else begin
        md_en = 1'b0; md_op = 3'd0;
      end
      tick();
    end
    md_en = 1'b0; md_op = 3'd0;
    chk("stall_idle", 32'(stall_md), 32'd0);
    chk("stall_busy_low", 32'(busy), 32'd0);
    chk("mthi_ignored_hi", hi, 32'h00000003);
    chk("mul_commit_lo", lo, 32'h00000000);
    hilo_sel = 1'b1; #1;
    chk("mfhi_hilo_E", hilo_E, 32'h00000003);
    hilo_sel = 1'b0; #1;
    chk("mflo_hilo_E", hilo_E, 32'h00000000);
    md_use_D = 1'b0;

    // Reset in the third busy cycle of a div discards it.
    issue(3'd5, 32'h11111111, 32'd0);
    issue(3'd4, 32'd100, 32'd7);
    tick(); tick();
    chk("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy_after", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (15) tick();
    chk("rst_no_commit_hi", hi, 32'd0);
    chk("rst_no_commit_lo", lo, 32'd0);
    chk("rst_no_commit_busy", 32'(busy), 32'd0);

    // Random ops against the reference model.
    mh = 32'd0; ml = 32'd0;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      ref_md(op, a, b, mh, ml, ecyc);
      issue(op, a, b);
      wait_idle(n, 1'b1, hold_ok);
      chk($sformatf("rnd%0d_op%0d_cycles", i, op), 32'(n), 32'(ecyc));
      chk($sformatf("rnd%0d_op%0d_hold", i, op), 32'(hold_ok), 32'd1);
      chk($sformatf("rnd%0d_op%0d_hi", i, op), hi, mh);
      chk($sformatf("rnd%0d_op%0d_lo", i, op), lo, ml);
      hilo_sel = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd%0d_hilo_E", i), hilo_E, hilo_sel ? mh : ml);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
